// File: rtl/fpa_seq.sv
// fpa_seq: multi-cycle floating-point adder/subtractor with a valid/ready handshake.
// Operands are {sign, exponent, fraction}. Denormals are flushed to zero. Rounding is
// round-to-nearest-even.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_ready   operand handshake; in_ready is high only in IDLE
//   in1, in2, op         operands A and B; op=1 selects A-B
//   out_valid, out_ready result handshake; out_valid is high only in DONE
//   out, flags           result and {overflow, invalid, inexact}
module fpa_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in1,
    input  logic [EXP_W+MAN_W:0]   in2,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [2:0]             flags
);
    localparam int unsigned W    = 1 + EXP_W + MAN_W;
    localparam int unsigned SW   = MAN_W + 4;  // hidden + fraction + guard/round/sticky
    localparam int unsigned SUMW = MAN_W + 5;  // SW plus carry

    typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StRound, StDone} state_e;

    state_e            state_q, state_d;
    logic              a_sign_q, a_sign_d, b_sign_q, b_sign_d;
    logic [EXP_W-1:0]  a_exp_q, a_exp_d, b_exp_q, b_exp_d;
    logic [MAN_W:0]    a_man_q, a_man_d, b_man_q, b_man_d;
    logic              sign_q, sign_d, sub_q, sub_d;
    logic [EXP_W:0]    exp_q, exp_d;  // one spare bit so rounding overflow is visible
    logic [SW-1:0]     big_q, big_d, small_q, small_d;
    logic [SUMW-1:0]   sum_q, sum_d;
    logic [W-1:0]      out_q, out_d;
    logic [2:0]        flags_q, flags_d;

    localparam logic [EXP_W-1:0] ExpOnes = {EXP_W{1'b1}};
    localparam logic [EXP_W:0]   ExpOne  = {{EXP_W{1'b0}}, 1'b1};
    localparam logic [W-1:0]     QNan    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    // Operand decode at capture.
    logic [EXP_W-1:0] a_exp_in, b_exp_in;
    logic [MAN_W-1:0] a_frac_in, b_frac_in;
    logic             b_sign_eff, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, invalid;

    assign a_exp_in   = in1[W-2:MAN_W];
    assign b_exp_in   = in2[W-2:MAN_W];
    assign a_frac_in  = in1[MAN_W-1:0];
    assign b_frac_in  = in2[MAN_W-1:0];
    assign b_sign_eff = in2[W-1] ^ op;
    assign a_nan      = (a_exp_in == ExpOnes) && (a_frac_in != '0);
    assign b_nan      = (b_exp_in == ExpOnes) && (b_frac_in != '0);
    assign a_inf      = (a_exp_in == ExpOnes) && (a_frac_in == '0);
    assign b_inf      = (b_exp_in == ExpOnes) && (b_frac_in == '0);
    assign a_zero     = (a_exp_in == '0);
    assign b_zero     = (b_exp_in == '0);
    assign invalid    = a_nan || b_nan || (a_inf && b_inf && (in1[W-1] != b_sign_eff));

    // Alignment: larger magnitude becomes the big operand.
    logic             a_ge_b, far;
    logic [EXP_W-1:0] big_exp, small_exp, diff;
    logic [MAN_W:0]   big_man, small_man;
    logic [SW-1:0]    small_ext, lost_mask, small_aligned;

    assign a_ge_b    = {a_exp_q, a_man_q} >= {b_exp_q, b_man_q};
    assign big_exp   = a_ge_b ? a_exp_q : b_exp_q;
    assign small_exp = a_ge_b ? b_exp_q : a_exp_q;
    assign big_man   = a_ge_b ? a_man_q : b_man_q;
    assign small_man = a_ge_b ? b_man_q : a_man_q;
    assign diff      = big_exp - small_exp;
    assign small_ext = {small_man, 3'b000};
    assign lost_mask = (SW'(1) << diff) - SW'(1);
    assign far       = 32'(diff) >= MAN_W + 3;
    // Far shifts leave only sticky; the hidden bit guarantees it is set.
    assign small_aligned = far ? {{(SW-1){1'b0}}, 1'b1}
                               : ((small_ext >> diff)
                                  | {{(SW-1){1'b0}}, |(small_ext & lost_mask)});

    // Round to nearest even.
    logic [MAN_W:0]   rnd_man;
    logic [MAN_W+1:0] rnd_sum;
    logic [MAN_W-1:0] rnd_frac;
    logic [EXP_W:0]   rnd_exp;
    logic             round_up, inexact;

    assign rnd_man  = sum_q[MAN_W+3:3];
    assign inexact  = |sum_q[2:0];
    assign round_up = sum_q[2] & (sum_q[1] | sum_q[0] | rnd_man[0]);
    assign rnd_sum  = {1'b0, rnd_man} + {{(MAN_W+1){1'b0}}, round_up};
    assign rnd_frac = rnd_sum[MAN_W+1] ? rnd_sum[MAN_W:1] : rnd_sum[MAN_W-1:0];
    assign rnd_exp  = rnd_sum[MAN_W+1] ? exp_q + ExpOne : exp_q;

    always_comb begin
        state_d  = state_q;
        a_sign_d = a_sign_q;
        a_exp_d  = a_exp_q;
        a_man_d  = a_man_q;
        b_sign_d = b_sign_q;
        b_exp_d  = b_exp_q;
        b_man_d  = b_man_q;
        sign_d   = sign_q;
        sub_d    = sub_q;
        exp_d    = exp_q;
        big_d    = big_q;
        small_d  = small_q;
        sum_d    = sum_q;
        out_d    = out_q;
        flags_d  = flags_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StDone;
                    flags_d = 3'b000;
                    if (invalid) begin
                        out_d   = QNan;
                        flags_d = 3'b010;
                    end else if (a_inf) begin
                        out_d = in1;
                    end else if (b_inf) begin
                        out_d = {b_sign_eff, in2[W-2:0]};
                    end else if (a_zero && b_zero) begin
                        out_d = {in1[W-1] & b_sign_eff, {(W-1){1'b0}}};
                    end else if (a_zero) begin
                        out_d = {b_sign_eff, in2[W-2:0]};
                    end else if (b_zero) begin
                        out_d = in1;
                    end else begin
                        state_d  = StAlign;
                        a_sign_d = in1[W-1];
                        a_exp_d  = a_exp_in;
                        a_man_d  = {1'b1, a_frac_in};
                        b_sign_d = b_sign_eff;
                        b_exp_d  = b_exp_in;
                        b_man_d  = {1'b1, b_frac_in};
                    end
                end
            end
            StAlign: begin
                sign_d  = a_ge_b ? a_sign_q : b_sign_q;
                sub_d   = a_sign_q ^ b_sign_q;
                exp_d   = {1'b0, big_exp};
                big_d   = {big_man, 3'b000};
                small_d = small_aligned;
                state_d = StAdd;
            end
            StAdd: begin
                sum_d   = sub_q ? {1'b0, big_q} - {1'b0, small_q}
                                : {1'b0, big_q} + {1'b0, small_q};
                state_d = StNorm;
            end
            StNorm: begin
                if (sum_q[SUMW-1]) begin
                    sum_d   = {1'b0, sum_q[SUMW-1:2], sum_q[1] | sum_q[0]};
                    exp_d   = exp_q + ExpOne;
                    state_d = StRound;
                end else if (sum_q[SUMW-2]) begin
                    state_d = StRound;
                end else if (sum_q == '0) begin
                    out_d   = '0;
                    flags_d = 3'b000;
                    state_d = StDone;
                end else if (exp_q == ExpOne) begin
                    // Next left shift would reach exponent 0: flush.
                    out_d   = {sign_q, {(W-1){1'b0}}};
                    flags_d = 3'b001;
                    state_d = StDone;
                end else begin
                    sum_d = sum_q << 1;
                    exp_d = exp_q - ExpOne;
                end
            end
            StRound: begin
                state_d = StDone;
                if (rnd_exp >= {1'b0, ExpOnes}) begin
                    out_d   = {sign_q, ExpOnes, {MAN_W{1'b0}}};
                    flags_d = 3'b101;
                end else begin
                    out_d   = {sign_q, rnd_exp[EXP_W-1:0], rnd_frac};
                    flags_d = {2'b00, inexact};
                end
            end
            StDone: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_sign_q <= 1'b0;
            a_exp_q  <= '0;
            a_man_q  <= '0;
            b_sign_q <= 1'b0;
            b_exp_q  <= '0;
            b_man_q  <= '0;
            sign_q   <= 1'b0;
            sub_q    <= 1'b0;
            exp_q    <= '0;
            big_q    <= '0;
            small_q  <= '0;
            sum_q    <= '0;
            out_q    <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_sign_q <= a_sign_d;
            a_exp_q  <= a_exp_d;
            a_man_q  <= a_man_d;
            b_sign_q <= b_sign_d;
            b_exp_q  <= b_exp_d;
            b_man_q  <= b_man_d;
            sign_q   <= sign_d;
            sub_q    <= sub_d;
            exp_q    <= exp_d;
            big_q    <= big_d;
            small_q  <= small_d;
            sum_q    <= sum_d;
            out_q    <= out_d;
            flags_q  <= flags_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign out       = out_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fpa_seq.sv
// Directed bench for fpa_seq (single precision). Latency is the number of edges after
// the capture edge until out_valid is seen; specials reach DONE on the capture edge
// itself, so their count here is 0.
module tb_fpa_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in1 = '0;
    logic [31:0] in2 = '0;
    logic        op = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic [2:0]  flags;

    int nvec = 0;
    int errs = 0;

    fpa_seq #(.EXP_W(8), .MAN_W(23)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Capture one operation and count edges until out_valid (bounded).
    task automatic capture(input logic [31:0] a, input logic [31:0] b, input logic o,
                           output int lat);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        in1 = a;
        in2 = b;
        op = o;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic o, input logic [31:0] exp_out, input logic [2:0] exp_flags,
                       input int exp_lat);
        int lat;
        capture(a, b, o, lat);
        chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".out"}, out, exp_out);
        chk({tag, ".flags"}, 32'(flags), 32'(exp_flags));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, ".idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int lat;
        step();
        step();
        rst = 1'b0;
        chk("reset.out", out, 32'h0);
        chk("reset.flags", 32'(flags), 32'h0);
        chk("reset.out_valid", 32'(out_valid), 32'h0);
        chk("reset.in_ready", 32'(in_ready), 32'h1);

        run("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 3'b000, 4);
        run("one_minus_3q", 32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000, 6);
        run("sum_1p5_2p25", 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 3'b000, 4);
        run("one_minus_two", 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 3'b000, 5);
        run("tie_even", 32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b001, 4);
        run("round_up", 32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001, 3'b001, 4);
        run("overflow", 32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b101, 4);
        run("cancel", 32'h40490FDB, 32'h40490FDB, 1'b1, 32'h00000000, 3'b000, 3);
        run("underflow", 32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 3'b001, 3);
        run("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 3'b010, 0);
        run("inf_plus_one", 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000, 0);
        run("nan_in", 32'h3F800000, 32'h7F800001, 1'b0, 32'h7FC00000, 3'b010, 0);
        run("negz_plus_negz", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 3'b000, 0);
        run("negz_minus_negz", 32'h80000000, 32'h80000000, 1'b1, 32'h00000000, 3'b000, 0);
        run("zero_minus_one", 32'h00000000, 32'h3F800000, 1'b1, 32'hBF800000, 3'b000, 0);
        run("denorm_flush", 32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000, 0);

        // Result held while the consumer stalls.
        capture(32'h3F800000, 32'h3F800000, 1'b0, lat);
        chk("stall.lat", 32'(lat), 32'd4);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.out", out, 32'h40000000);
            chk("stall.flags", 32'(flags), 32'h0);
            chk("stall.out_valid", 32'(out_valid), 32'h1);
            chk("stall.in_ready", 32'(in_ready), 32'h0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset while in ALIGN discards the operation and clears out.
        in1 = 32'h3F800000;
        in2 = 32'h3F800000;
        op = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_align.out_valid", 32'(out_valid), 32'h0);
        chk("rst_align.out", out, 32'h0);
        chk("rst_align.flags", 32'(flags), 32'h0);
        chk("rst_align.in_ready", 32'(in_ready), 32'h1);
        run("after_reset", 32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 3'b000, 4);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
